ps2_host_tx: RTL

Host-to-device PS/2 transmitter. It sends command bytes to the keyboard or mouse, such as LED set (0xED), reset (0xFF) and enable reporting (0xF4). It is the opposite direction to the existing PS/2 receive path. It drives the open-collector `clkps2`/`dataps2` (or `mouseclk`/`mousedata`) pads through active-high pull-low enables, and signals the companion receiver to ignore bus activity while a transmission is in progress.

---
 rtl/ps2_host_tx.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Holds the clock low for the inhibit period, then asserts the start bit and
// releases the clock. After that it shifts out eight data bits (LSB first),
// odd parity and the stop bit on device clock falling edges, and samples the
// device ACK on the 11th edge.
// Pads are open-collector: *_oe = 1 pulls the line low, 0 releases it.
// Optional feature: define PS2_TX_GLITCH_FILTER_EN to insert an 8-sample
// glitch filter between the synchronizers and the edge detector.
module ps2_host_tx #(
  parameter int CLKFREQ    = 28000,
  parameter int INHIBIT_US = 120,
  parameter int TIMEOUT_US = 15000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  input  logic [7:0] din,
  input  logic       send,
  output logic       busy,
  output logic       rx_inhibit,
  output logic       done,
  output logic       error,
  output logic       ack_ok
);

  localparam int N_INH = CLKFREQ * INHIBIT_US / 1000;
  localparam int N_TO  = CLKFREQ * TIMEOUT_US / 1000;

  // The last count value of each phase. The counter runs from 0, so a phase
  // lasting N cycles ends when the counter reads N-1.
  localparam logic [18:0] INH_LAST = 19'(N_INH - 1);
  localparam logic [18:0] TO_LAST  = 19'(N_TO - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    BITS,
    ACK,
    WAITIDLE
  } state_t;

  state_t      state;
  logic [18:0] cnt;
  logic [3:0]  bitcnt;
  logic [9:0]  shift;

  logic clk_s1;
  logic clk_s2;
  logic data_s1;
  logic data_s2;
  logic clk_c;
  logic data_c;
  logic clk_prev;
  logic fall;

  // Two-flop synchronizers for the asynchronous pad inputs; they reset to the idle-high bus level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2clk_in;
      clk_s2  <= clk_s1;
      data_s1 <= ps2data_in;
      data_s2 <= data_s1;
    end
  end

`ifdef PS2_TX_GLITCH_FILTER_EN
  logic [2:0] clk_run;
  logic [2:0] data_run;
  logic       clk_f;
  logic       data_f;

  // A filtered line follows its input only after 8 consecutive samples disagree with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_f    <= 1'b1;
      data_f   <= 1'b1;
      clk_run  <= 3'd0;
      data_run <= 3'd0;
    end else begin
      if (clk_s2 == clk_f) begin
        clk_run <= 3'd0;
      end else if (clk_run == 3'd7) begin
        clk_f   <= clk_s2;
        clk_run <= 3'd0;
      end else begin
        clk_run <= clk_run + 3'd1;
      end

      if (data_s2 == data_f) begin
        data_run <= 3'd0;
      end else if (data_run == 3'd7) begin
        data_f   <= data_s2;
        data_run <= 3'd0;
      end else begin
        data_run <= data_run + 3'd1;
      end
    end
  end

  assign clk_c  = clk_f;
  assign data_c = data_f;
`else
  assign clk_c  = clk_s2;
  assign data_c = data_s2;
`endif

  // The previous conditioned clock level, used to detect device falling edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_prev <= 1'b1;
    end else begin
      clk_prev <= clk_c;
    end
  end

  assign fall = clk_prev & ~clk_c;

  // The receiver must ignore the bus for as long as the transmitter owns it.
  assign rx_inhibit = busy;

  // Transmit sequencer. A single counter times the inhibit period and then
  // serves as the watchdog, restarting at every device clock falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 19'd0;
      bitcnt     <= 4'd0;
      shift      <= 10'd0;
      ps2clk_oe  <= 1'b0;
      ps2data_oe <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      ack_ok     <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          ps2clk_oe  <= 1'b0;
          ps2data_oe <= 1'b0;
          if (send) begin
            shift     <= {1'b1, ~^din, din};
            cnt       <= 19'd0;
            bitcnt    <= 4'd0;
            busy      <= 1'b1;
            ps2clk_oe <= 1'b1;
            state     <= INHIBIT;
          end
        end

        INHIBIT: begin
          if (cnt == INH_LAST) begin
            ps2data_oe <= 1'b1;
            state      <= START;
          end else begin
            cnt <= cnt + 19'd1;
          end
        end

        START: begin
          ps2clk_oe <= 1'b0;
          cnt       <= 19'd0;
          bitcnt    <= 4'd0;
          state     <= BITS;
        end

        BITS, ACK, WAITIDLE: begin
          if (cnt == TO_LAST) begin
            ps2clk_oe  <= 1'b0;
            ps2data_oe <= 1'b0;
            ack_ok     <= 1'b0;
            error      <= 1'b1;
            busy       <= 1'b0;
            cnt        <= 19'd0;
            state      <= IDLE;
          end else begin
            cnt <= fall ? 19'd0 : cnt + 19'd1;
            case (state)
              BITS: begin
                if (fall) begin
                  ps2data_oe <= ~shift[0];
                  shift      <= {1'b0, shift[9:1]};
                  bitcnt     <= bitcnt + 4'd1;
                  if (bitcnt == 4'd9) begin
                    state <= ACK;
                  end
                end
              end
              ACK: begin
                if (fall) begin
                  ack_ok <= ~data_c;
                  state  <= WAITIDLE;
                end
              end
              WAITIDLE: begin
                if (clk_c && data_c) begin
                  done  <= ack_ok;
                  error <= ~ack_ok;
                  busy  <= 1'b0;
                  cnt   <= 19'd0;
                  state <= IDLE;
                end
              end
              default: begin
              end
            endcase
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
